// File: rtl/serpent_en_iter_ctrl.sv
// Iterative Serpent encryption controller: one round datapath reused over NUM_ROUNDS passes.
// Defining SERPENT_CTRL_ABORT_EN adds an i_abort input that drops the block in flight.
module serpent_en_iter_ctrl #(
    parameter int NUM_ROUNDS = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [127:0] i_data,
    input  logic         i_key_rdy,
    output logic [5:0]   o_sk_addr,
    input  logic [127:0] i_sk_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_data,
    output logic         o_busy
`ifdef SERPENT_CTRL_ABORT_EN
    ,
    input  logic         i_abort
`endif
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);
    localparam logic [5:0] WHITEN_IDX = 6'(NUM_ROUNDS);

    // S-box rows, entry 0 held in the most significant nibble.
    localparam logic [63:0] SBOX [8] = '{
        64'h38F1A65BED42709C,
        64'hFC27905A1BE86D34,
        64'h86793CAFD1E40B52,
        64'h0FB8C963D124A75E,
        64'h1F83C0B6254A9E7D,
        64'hF52B4A9C03E8D671,
        64'h72C5846BE91FD3A0,
        64'h1DF0E82B74CA9356
    };

    state_t       state;
    logic [5:0]   round_cnt;
    logic [127:0] blk;
    logic [127:0] round_out;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Round datapath: key mix, bitsliced S-box of round%8, linear transform.
    // The last round skips the transform; the whitening XOR happens in FINAL.
    function automatic logic [127:0] serpent_round(input logic [127:0] blk_in,
                                                   input logic [127:0] subkey,
                                                   input logic [5:0]   rnd);
        logic [127:0] mixed;
        logic [63:0]  row;
        logic [3:0]   nib;
        logic [3:0]   sout;
        logic [31:0]  x0, x1, x2, x3;
        mixed = blk_in ^ subkey;
        row   = SBOX[rnd[2:0]];
        nib   = '0;
        sout  = '0;
        x0    = '0;
        x1    = '0;
        x2    = '0;
        x3    = '0;
        for (int i = 0; i < 32; i++) begin
            nib   = {mixed[96+i], mixed[64+i], mixed[32+i], mixed[i]};
            sout  = row[{~nib, 2'b00} +: 4];
            x0[i] = sout[0];
            x1[i] = sout[1];
            x2[i] = sout[2];
            x3[i] = sout[3];
        end
        if (rnd != LAST_ROUND) begin
            x0 = rotl(x0, 13);
            x2 = rotl(x2, 3);
            x1 = x1 ^ x0 ^ x2;
            x3 = x3 ^ x2 ^ (x0 << 3);
            x1 = rotl(x1, 1);
            x3 = rotl(x3, 7);
            x0 = x0 ^ x1 ^ x3;
            x2 = x2 ^ x3 ^ (x1 << 7);
            x0 = rotl(x0, 5);
            x2 = rotl(x2, 22);
        end
        return {x3, x2, x1, x0};
    endfunction

    assign round_out = serpent_round(blk, i_sk_data, round_cnt);
    assign o_busy    = (state == ROUND) || (state == FINAL);

    always_comb begin
        o_sk_addr = '0;
        case (state)
            ROUND:   o_sk_addr = round_cnt;
            FINAL:   o_sk_addr = WHITEN_IDX;
            default: o_sk_addr = '0;
        endcase
    end

    // o_ready is registered, so it is recomputed on every edge that lands in IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            round_cnt <= '0;
            blk       <= '0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_ready   <= 1'b0;
        end
`ifdef SERPENT_CTRL_ABORT_EN
        else if (i_abort && o_busy) begin
            state     <= IDLE;
            round_cnt <= '0;
            blk       <= '0;
            o_ready   <= i_key_rdy;
        end
`endif
        else begin
            case (state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        blk       <= i_data;
                        round_cnt <= '0;
                        o_ready   <= 1'b0;
                        state     <= ROUND;
                    end else begin
                        o_ready <= i_key_rdy;
                    end
                end
                ROUND: begin
                    if (i_key_rdy) begin
                        blk       <= round_out;
                        round_cnt <= round_cnt + 6'd1;
                        if (round_cnt == LAST_ROUND) begin
                            state <= FINAL;
                        end
                    end
                end
                FINAL: begin
                    if (i_key_rdy) begin
                        o_data  <= blk ^ i_sk_data;
                        o_valid <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= i_key_rdy;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serpent_en_iter_ctrl.sv
// Directed bench for serpent_en_iter_ctrl: reset, latency, back-to-back, stalls,
// backpressure, async reset and (with SERPENT_CTRL_ABORT_EN) abort.
module tb_serpent_en_iter_ctrl;
    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [127:0] i_data;
    logic         i_key_rdy;
    logic [5:0]   o_sk_addr;
    logic [127:0] i_sk_data;
    logic         o_valid;
    logic         i_ready;
    logic [127:0] o_data;
    logic         o_busy;
`ifdef SERPENT_CTRL_ABORT_EN
    logic         i_abort;
`endif

    logic [127:0] sk [0:63];
    int vectors     = 0;
    int miscompares = 0;
    int edge_cnt    = 0;

    int sbox_tab [8][16] = '{
        '{ 3,  8, 15,  1, 10,  6,  5, 11, 14, 13,  4,  2,  7,  0,  9, 12},
        '{15, 12,  2,  7,  9,  0,  5, 10,  1, 11, 14,  8,  6, 13,  3,  4},
        '{ 8,  6,  7,  9,  3, 12, 10, 15, 13,  1, 14,  4,  0, 11,  5,  2},
        '{ 0, 15, 11,  8, 12,  9,  6,  3, 13,  1,  2,  4, 10,  7,  5, 14},
        '{ 1, 15,  8,  3, 12,  0, 11,  6,  2,  5,  4, 10,  9, 14,  7, 13},
        '{15,  5,  2, 11,  4, 10,  9, 12,  0,  3, 14,  8, 13,  6,  7,  1},
        '{ 7,  2, 12,  5,  8,  4,  6, 11, 14,  9,  1, 15, 13,  3, 10,  0},
        '{ 1, 13, 15,  0, 14,  8,  2, 11,  7,  4, 12, 10,  9,  3,  5,  6}
    };

    always #5 i_clk = ~i_clk;

    assign i_sk_data = sk[o_sk_addr];

    serpent_en_iter_ctrl #(.NUM_ROUNDS(32)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_data    (i_data),
        .i_key_rdy (i_key_rdy),
        .o_sk_addr (o_sk_addr),
        .i_sk_data (i_sk_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_busy    (o_busy)
`ifdef SERPENT_CTRL_ABORT_EN
        ,
        .i_abort   (i_abort)
`endif
    );

    // Reference cipher over the current subkey table, full 32 rounds.
    function automatic logic [127:0] model(input logic [127:0] pt);
        logic [31:0]  a, b, c, d, na, nb, nc, nd;
        logic [127:0] k;
        int v, s;
        {d, c, b, a} = pt;
        na = '0; nb = '0; nc = '0; nd = '0;
        for (int r = 0; r < 32; r++) begin
            k = sk[r];
            a = a ^ k[31:0];
            b = b ^ k[63:32];
            c = c ^ k[95:64];
            d = d ^ k[127:96];
            for (int col = 0; col < 32; col++) begin
                v = {28'd0, d[col], c[col], b[col], a[col]};
                s = sbox_tab[r % 8][v];
                na[col] = s[0];
                nb[col] = s[1];
                nc[col] = s[2];
                nd[col] = s[3];
            end
            a = na; b = nb; c = nc; d = nd;
            if (r != 31) begin
                a = {a[18:0], a[31:19]};
                c = {c[28:0], c[31:29]};
                b = b ^ a ^ c;
                d = d ^ c ^ (a << 3);
                b = {b[30:0], b[31]};
                d = {d[24:0], d[31:25]};
                a = a ^ b ^ d;
                c = c ^ d ^ (b << 7);
                a = {a[26:0], a[31:27]};
                c = {c[9:0], c[31:10]};
            end
        end
        return {d, c, b, a} ^ sk[32];
    endfunction

    task automatic tick();
        @(negedge i_clk);
        edge_cnt++;
    endtask

    task automatic check_word(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        vectors++;
        assert (got == exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Offer one block, step over the accepting edge and restart the edge count there.
    task automatic apply_stimulus(input logic [127:0] pt);
        check_bit("ready_before_accept", o_ready, 1'b1);
        i_valid = 1'b1;
        i_data  = pt;
        tick();
        i_valid  = 1'b0;
        i_data   = ~pt;
        edge_cnt = 0;
        check_bit("busy_after_accept", o_busy, 1'b1);
        check_int("sk_addr_first_round", int'(o_sk_addr), 0);
    endtask

    task automatic check_output(input int budget);
        while (o_valid !== 1'b1 && edge_cnt < budget) tick();
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] blocks [4];
        logic [127:0] exp_ct;
        logic [127:0] pt;
        int  acc_t [4];
        int  acc_n, out_n, cyc, exp_addr;
        bit  accepting;
        bit  saw_valid;

        $display("[TB] serpent_en_iter_ctrl bench start");
        i_rst_n   = 1'b0;
        i_valid   = 1'b0;
        i_data    = '0;
        i_key_rdy = 1'b1;
        i_ready   = 1'b1;
`ifdef SERPENT_CTRL_ABORT_EN
        i_abort   = 1'b0;
`endif
        for (int i = 0; i < 64; i++) sk[i] = '0;
        for (int i = 0; i < 4; i++) acc_t[i] = 0;
        saw_valid = 1'b0;

        tick();
        tick();
        check_bit("rst_valid", o_valid, 1'b0);
        check_bit("rst_ready", o_ready, 1'b0);
        check_bit("rst_busy", o_busy, 1'b0);
        check_int("rst_sk_addr", int'(o_sk_addr), 0);
        check_word("rst_data", o_data, '0);
        i_rst_n = 1'b1;
        tick();
        check_bit("ready_after_reset", o_ready, 1'b1);

        // Zero subkeys, zero plaintext.
        exp_ct = model('0);
        apply_stimulus('0);
        check_output(60);
        check_int("t1_latency", edge_cnt, 33);
        check_word("t1_data", o_data, exp_ct);
        tick();
        check_bit("t1_valid_drop", o_valid, 1'b0);
        check_bit("t1_ready_idle", o_ready, 1'b1);

        // Back-to-back with i_valid held high.
        for (int i = 0; i < 64; i++) sk[i] = rand128();
        for (int i = 0; i < 4; i++) blocks[i] = rand128();
        acc_n = 0; out_n = 0; cyc = 0; exp_addr = 0;
        i_valid = 1'b1;
        i_data  = blocks[0];
        while (out_n < 4 && cyc < 400) begin
            if (o_busy) begin
                check_int("t2_sk_addr", int'(o_sk_addr), exp_addr);
                exp_addr++;
            end
            if (o_valid) begin
                check_word("t2_data", o_data, model(blocks[out_n]));
                out_n++;
            end
            accepting = i_valid && o_ready;
            if (accepting && acc_n < 4) begin
                acc_t[acc_n] = cyc;
                acc_n++;
            end
            tick();
            cyc++;
            if (accepting) begin
                exp_addr = 0;
                if (acc_n < 4) i_data = blocks[acc_n];
                else begin
                    i_valid = 1'b0;
                    i_data  = '0;
                end
            end
        end
        i_valid = 1'b0;
        check_int("t2_outputs", out_n, 4);
        check_int("t2_accepts", acc_n, 4);
        for (int i = 1; i < 4; i++) check_int("t2_interval", acc_t[i] - acc_t[i-1], 35);

        // Key-schedule stalls at round 10 and in FINAL.
        pt     = rand128();
        exp_ct = model(pt);
        apply_stimulus(pt);
        repeat (10) tick();
        check_int("t3_round10", int'(o_sk_addr), 10);
        i_key_rdy = 1'b0;
        repeat (5) begin
            tick();
            check_int("t3_hold10", int'(o_sk_addr), 10);
        end
        i_key_rdy = 1'b1;
        while (o_sk_addr != 6'd32 && edge_cnt < 80) tick();
        check_int("t3_final_edge", edge_cnt, 37);
        i_key_rdy = 1'b0;
        repeat (3) begin
            tick();
            check_bit("t3_final_hold", o_valid, 1'b0);
        end
        check_int("t3_final_addr", int'(o_sk_addr), 32);
        i_key_rdy = 1'b1;
        check_output(80);
        check_int("t3_latency", edge_cnt, 41);
        check_word("t3_data", o_data, exp_ct);
        tick();

        // Downstream backpressure for 20 cycles.
        pt      = rand128();
        exp_ct  = model(pt);
        i_ready = 1'b0;
        apply_stimulus(pt);
        check_output(60);
        check_int("t4_latency", edge_cnt, 33);
        check_word("t4_data", o_data, exp_ct);
        repeat (20) begin
            tick();
            check_bit("t4_hold_valid", o_valid, 1'b1);
            check_word("t4_hold_data", o_data, exp_ct);
            check_bit("t4_hold_ready", o_ready, 1'b0);
        end
        i_ready = 1'b1;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        check_bit("t4_release_valid", o_valid, 1'b0);
        check_bit("t4_release_ready", o_ready, 1'b1);
        check_bit("t4_release_busy", o_busy, 1'b0);

        // Asynchronous reset in the middle of round 17.
        apply_stimulus(rand128());
        repeat (17) tick();
        check_int("t5_round17", int'(o_sk_addr), 17);
        #2 i_rst_n = 1'b0;
        #1;
        check_bit("t5_rst_valid", o_valid, 1'b0);
        check_bit("t5_rst_ready", o_ready, 1'b0);
        check_bit("t5_rst_busy", o_busy, 1'b0);
        check_int("t5_rst_sk_addr", int'(o_sk_addr), 0);
        check_word("t5_rst_data", o_data, '0);
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        check_bit("t5_ready_after", o_ready, 1'b1);
        pt     = rand128();
        exp_ct = model(pt);
        apply_stimulus(pt);
        check_output(60);
        check_int("t5_latency", edge_cnt, 33);
        check_word("t5_data", o_data, exp_ct);
        tick();

`ifdef SERPENT_CTRL_ABORT_EN
        // Abort during round 5, then a clean block.
        apply_stimulus(rand128());
        repeat (5) tick();
        check_int("t6_round5", int'(o_sk_addr), 5);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check_bit("t6_abort_busy", o_busy, 1'b0);
        check_bit("t6_abort_ready", o_ready, 1'b1);
        check_int("t6_abort_addr", int'(o_sk_addr), 0);
        saw_valid = 1'b0;
        repeat (40) begin
            tick();
            if (o_valid === 1'b1) saw_valid = 1'b1;
        end
        check_bit("t6_no_valid", saw_valid, 1'b0);
        pt     = rand128();
        exp_ct = model(pt);
        apply_stimulus(pt);
        check_output(60);
        check_int("t6_latency", edge_cnt, 33);
        check_word("t6_data", o_data, exp_ct);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
